lab3_qs_onchip_mem_arbiter: RTL and testbench
=============================================

# lab3_qs_onchip_mem_arbiter

Two-master round-robin arbiter for the lab3_qs single-port on-chip RAM (32-bit, 10000 words, 14-bit word address, byte enables, unregistered output). It lets two Avalon-MM style requesters, master 0 and master 1, share the single RAM port. It issues at most one access per cycle, returns read data with a fixed one-cycle latency tagged to the issuing master, and traps out-of-range addresses.

## Interface
Parameters:
- ADDR_W, 14, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- NUM_WORDS, 10000, implemented depth; addresses >= NUM_WORDS are out of range

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  word address (N = 0, 1)
- mN_byteenable  in  BE_W  write byte lanes
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  one-cycle pulse qualifying mN_readdata
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken, constant 1 out of reset
- mem_readdata  in  DATA_W  from RAM, valid the cycle after address
- oor_err  out  1  sticky, set on any out-of-range access
- oor_count  out  8  saturating count of out-of-range accesses

## Operation
- Request: reqN = mN_read | mN_write. mN_read and mN_write asserted together count as a write.
- Grant is combinational within the cycle. Exactly one master is granted when any request is present.
  - Only one reqN: that master wins.
  - Both requesting: the master selected by rr_ptr wins.
- rr_ptr is 1 bit, reset 0. After a cycle in which both requested, it toggles to the loser. Otherwise it is unchanged.
- Winner sees waitrequest=0 and the access completes in that cycle. Loser, and any idle master, sees waitrequest=1. A master holds its request stable until waitrequest=0.
- Worst-case wait under continuous contention: 1 cycle.
- In-range winner: mem_chipselect=1, and address, byteenable and writedata are muxed from the winner. mem_write=1 only for a write.
- Out-of-range winner (address >= NUM_WORDS):
  - mem_chipselect=0 and mem_write=0. The access is still accepted (waitrequest=0).
  - oor_err is set; oor_count increments, saturating at 255.
  - A read returns 0x00000000 with the normal readdatavalid timing.
- Read tracking: registered rd_vld, rd_owner and rd_oor capture the accepted read.
  - The next cycle, the owner's readdatavalid=1 and readdata=mem_readdata, or 0 if rd_oor.
  - The non-owner's readdatavalid=0 and its readdata holds its previous value.
- No state machine beyond rr_ptr, the read tag and the error registers. Throughput is one access per cycle, back to back.

## Timing
- Reset values (asserted asynchronously):
  - Both waitrequest=1 while reset is high.
  - readdatavalid=0, readdata=0.
  - mem_chipselect=0, mem_write=0, mem_clken=0, mem_address/byteenable/writedata=0.
  - rr_ptr=0, oor_err=0, oor_count=0.
- Read latency: request accepted at edge k, data and readdatavalid presented in cycle k+1 and sampled at edge k+1.
- Write latency: the RAM is written at the acceptance edge. A read of the same address accepted the next cycle returns the new data.
- Reset asserted mid-read clears rd_vld. No readdatavalid is produced for that read after reset releases.
- Requests during reset are ignored and none are issued. The first grant can occur in the first cycle with reset low.

## Test plan
- Single read: m0 reads address 0x0005 (RAM preloaded 0xA5A5_0005) -> m0_waitrequest=0 in cycle 0; m0_readdatavalid=1 with 0xA5A5_0005 in cycle 1; m1 sees no valid.
- Contention:
  - m0 and m1 both hold reads of 0x0010/0x0020 for 4 cycles after reset.
  - Grants go m0, m1, m0, m1; each master gets 2 valids of the correct data, each one cycle after its grant.
- Byte write then read:
  - m1 writes 0x1234_5678 to 0x0100 with byteenable 0xF, then 0xFFFF_FFFF with byteenable 0x2.
  - m0 then reads 0x0100 -> 0x1234_FF78.
- Out-of-range:
  - m0 writes address 10000, then reads 16383.
  - mem_chipselect stays 0; the read returns 0x0000_0000; oor_err=1; oor_count=2.
  - 300 further out-of-range accesses -> oor_count=255.
- Reset mid-read: m1 read accepted, reset pulsed before the next edge -> no m1_readdatavalid; all outputs at reset values; rr_ptr=0.
- Back-to-back: m0 alone issues 8 consecutive reads -> waitrequest never high; 8 consecutive readdatavalid pulses in order.

Source files
------------

// File: rtl/lab3_qs_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of the lab3_qs single-port on-chip RAM.
// One access per cycle, combinational grant, read data returned one cycle after
// acceptance to the issuing master, out-of-range accesses trapped and counted.
module lab3_qs_onchip_mem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int NUM_WORDS = 10000
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              oor_err,
    output logic [7:0]        oor_count
);

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

    // True when the word address lies outside the implemented depth.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= LIMIT);
    endfunction

    // Saturating increment for the out-of-range counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Round-robin pointer, read tag and error state
    logic              rr_ptr_q,     rr_ptr_d;
    logic              rd_vld_q,     rd_vld_d;
    logic              rd_owner_q,   rd_owner_d;
    logic              rd_oor_q,     rd_oor_d;
    logic              oor_err_q,    oor_err_d;
    logic [7:0]        oor_count_q,  oor_count_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;

    // Combinational arbitration results
    logic              req0, req1;
    logic              gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] win_addr;
    logic [BE_W-1:0]   win_be;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write;
    logic              win_oor;
    logic [DATA_W-1:0] rd_data;

    // Request decode and grant; nothing is requested or granted while in reset.
    always_comb begin
        req0    = ~reset & (m0_read | m0_write);
        req1    = ~reset & (m1_read | m1_write);
        // Under contention rr_ptr picks the winner (0 -> m0, 1 -> m1).
        gnt0    = req0 & (~req1 | ~rr_ptr_q);
        gnt1    = req1 & (~req0 |  rr_ptr_q);
        gnt_any = gnt0 | gnt1;
    end

    // Mux the winning master's command; read+write together counts as a write.
    always_comb begin
        win_addr  = gnt1 ? m1_address    : m0_address;
        win_be    = gnt1 ? m1_byteenable : m0_byteenable;
        win_wdata = gnt1 ? m1_writedata  : m0_writedata;
        win_write = gnt1 ? m1_write      : m0_write;
        win_oor   = gnt_any & addr_oor(win_addr);
    end

    // Drive the RAM port; out-of-range or idle cycles leave the RAM untouched.
    always_comb begin
        mem_clken      = ~reset;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt_any && !win_oor) begin
            mem_chipselect = 1'b1;
            mem_write      = win_write;
            mem_address    = win_addr;
            mem_byteenable = win_be;
            mem_writedata  = win_wdata;
        end
    end

    // Waitrequest: only the winner is released; everyone waits during reset.
    always_comb begin
        m0_waitrequest = ~gnt0;
        m1_waitrequest = ~gnt1;
    end

    // Next-state for rr_ptr: toggle to the loser only after a contended cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req0 && req1) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    // Capture the accepted read so its data can be steered next cycle.
    always_comb begin
        rd_vld_d   = gnt_any & ~win_write;
        rd_owner_d = gnt1;
        rd_oor_d   = win_oor;
    end

    // Sticky error flag and saturating out-of-range counter.
    always_comb begin
        oor_err_d   = oor_err_q;
        oor_count_d = oor_count_q;
        if (win_oor) begin
            oor_err_d   = 1'b1;
            oor_count_d = sat_inc(oor_count_q);
        end
    end

    // Read return path: owner sees RAM data (or zero for a trapped read),
    // the other master keeps showing whatever it last received.
    always_comb begin
        rd_data          = rd_oor_q ? '0 : mem_readdata;
        m0_readdatavalid = rd_vld_q & ~rd_owner_q;
        m1_readdatavalid = rd_vld_q &  rd_owner_q;
        rdata0_d         = m0_readdatavalid ? rd_data : rdata0_q;
        rdata1_d         = m1_readdatavalid ? rd_data : rdata1_q;
        m0_readdata      = rdata0_d;
        m1_readdata      = rdata1_d;
        oor_err          = oor_err_q;
        oor_count        = oor_count_q;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_owner_q  <= 1'b0;
            rd_oor_q    <= 1'b0;
            oor_err_q   <= 1'b0;
            oor_count_q <= 8'd0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rd_vld_q    <= rd_vld_d;
            rd_owner_q  <= rd_owner_d;
            rd_oor_q    <= rd_oor_d;
            oor_err_q   <= oor_err_d;
            oor_count_q <= oor_count_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_lab3_qs_onchip_mem_arbiter.sv
// Directed bench for the two-master on-chip RAM arbiter, with a behavioral RAM.
module tb_lab3_qs_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;
    logic        oor_err;
    logic [7:0]  oor_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lab3_qs_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .oor_err(oor_err), .oor_count(oor_count)
    );

    // Behavioral single-port RAM: registered read, byte-lane writes.
    logic [31:0] ram [0:9999];
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    typedef struct {
        logic        m0_rd, m0_wr; logic [13:0] m0_a; logic [3:0] m0_be; logic [31:0] m0_wd;
        logic        m1_rd, m1_wr; logic [13:0] m1_a; logic [3:0] m1_be; logic [31:0] m1_wd;
        logic        e_w0, e_w1, e_cs, e_mw; logic [13:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd;
        logic        e_rv0; logic [31:0] e_rd0; logic e_rv1; logic [31:0] e_rd1;
        logic        e_err; logic [7:0] e_cnt;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [13:0] a0, input logic [3:0] b0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [13:0] a1, input logic [3:0] b1, input logic [31:0] d1);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = b0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = b1; m1_writedata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_w0", {31'h0, m0_waitrequest}, 32'h1);
        chk("rst_w1", {31'h0, m1_waitrequest}, 32'h1);
        chk("rst_rv0", {31'h0, m0_readdatavalid}, 32'h0);
        chk("rst_rv1", {31'h0, m1_readdatavalid}, 32'h0);
        chk("rst_rd0", m0_readdata, 32'h0);
        chk("rst_rd1", m1_readdata, 32'h0);
        chk("rst_cs", {31'h0, mem_chipselect}, 32'h0);
        chk("rst_mw", {31'h0, mem_write}, 32'h0);
        chk("rst_clken", {31'h0, mem_clken}, 32'h0);
        chk("rst_addr", {18'h0, mem_address}, 32'h0);
        chk("rst_be", {28'h0, mem_byteenable}, 32'h0);
        chk("rst_wd", mem_writedata, 32'h0);
        chk("rst_err", {31'h0, oor_err}, 32'h0);
        chk("rst_cnt", {24'h0, oor_count}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 10000; i++) ram[i] = 32'hA5A5_0000 | i;

        //            m0: rd    wr    addr     be    wd             m1: rd    wr    addr     be    wd
        //            exp: w0   w1    cs    mw    addr     be    wd            rv0   rd0            rv1   rd1            err   cnt
        vt[0]  = '{1'b1,1'b0,14'h0005,4'hF,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b0,1'b1,1'b1,1'b0,14'h0005,4'h0,32'h0,         1'b0,32'h0,         1'b0,32'h0,         1'b0,8'd0};
        vt[1]  = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b1,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b1,32'hA5A50005,  1'b0,32'h0,         1'b0,8'd0};
        vt[2]  = '{1'b1,1'b0,14'h0010,4'hF,32'h0,        1'b1,1'b0,14'h0020,4'hF,32'h0,
                   1'b0,1'b1,1'b1,1'b0,14'h0010,4'h0,32'h0,         1'b0,32'hA5A50005,  1'b0,32'h0,         1'b0,8'd0};
        vt[3]  = '{1'b1,1'b0,14'h0010,4'hF,32'h0,        1'b1,1'b0,14'h0020,4'hF,32'h0,
                   1'b1,1'b0,1'b1,1'b0,14'h0020,4'h0,32'h0,         1'b1,32'hA5A50010,  1'b0,32'h0,         1'b0,8'd0};
        vt[4]  = '{1'b1,1'b0,14'h0010,4'hF,32'h0,        1'b1,1'b0,14'h0020,4'hF,32'h0,
                   1'b0,1'b1,1'b1,1'b0,14'h0010,4'h0,32'h0,         1'b0,32'hA5A50010,  1'b1,32'hA5A50020,  1'b0,8'd0};
        vt[5]  = '{1'b1,1'b0,14'h0010,4'hF,32'h0,        1'b1,1'b0,14'h0020,4'hF,32'h0,
                   1'b1,1'b0,1'b1,1'b0,14'h0020,4'h0,32'h0,         1'b1,32'hA5A50010,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[6]  = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b1,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b0,32'hA5A50010,  1'b1,32'hA5A50020,  1'b0,8'd0};
        vt[7]  = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b1,14'h0100,4'hF,32'h12345678,
                   1'b1,1'b0,1'b1,1'b1,14'h0100,4'hF,32'h12345678,  1'b0,32'hA5A50010,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[8]  = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b1,14'h0100,4'h2,32'hFFFFFFFF,
                   1'b1,1'b0,1'b1,1'b1,14'h0100,4'h2,32'hFFFFFFFF,  1'b0,32'hA5A50010,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[9]  = '{1'b1,1'b0,14'h0100,4'hF,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b0,1'b1,1'b1,1'b0,14'h0100,4'h0,32'h0,         1'b0,32'hA5A50010,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[10] = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b1,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b1,32'h1234FF78,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[11] = '{1'b0,1'b1,14'h2710,4'hF,32'hDEADBEEF, 1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b0,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b0,32'h1234FF78,  1'b0,32'hA5A50020,  1'b0,8'd0};
        vt[12] = '{1'b1,1'b0,14'h3FFF,4'hF,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b0,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b0,32'h1234FF78,  1'b0,32'hA5A50020,  1'b1,8'd1};
        vt[13] = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b1,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b1,32'h00000000,  1'b0,32'hA5A50020,  1'b1,8'd2};
        vt[14] = '{1'b1,1'b1,14'h0200,4'hF,32'hCAFEF00D, 1'b1,1'b0,14'h0005,4'hF,32'h0,
                   1'b0,1'b1,1'b1,1'b1,14'h0200,4'hF,32'hCAFEF00D,  1'b0,32'h00000000,  1'b0,32'hA5A50020,  1'b1,8'd2};
        vt[15] = '{1'b1,1'b0,14'h0200,4'hF,32'h0,        1'b1,1'b0,14'h0005,4'hF,32'h0,
                   1'b1,1'b0,1'b1,1'b0,14'h0005,4'h0,32'h0,         1'b0,32'h00000000,  1'b0,32'hA5A50020,  1'b1,8'd2};
        vt[16] = '{1'b1,1'b0,14'h0200,4'hF,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b0,1'b1,1'b1,1'b0,14'h0200,4'h0,32'h0,         1'b0,32'h00000000,  1'b1,32'hA5A50005,  1'b1,8'd2};
        vt[17] = '{1'b0,1'b0,14'h0000,4'h0,32'h0,        1'b0,1'b0,14'h0000,4'h0,32'h0,
                   1'b1,1'b1,1'b0,1'b0,14'h0000,4'h0,32'h0,         1'b1,32'hCAFEF00D,  1'b0,32'hA5A50005,  1'b1,8'd2};

        // Reset with requests pending: nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 1'b0, 14'h0005, 4'hF, 32'h0, 1'b1, 1'b0, 14'h0020, 4'hF, 32'h0);
        #2;
        chk_reset_values();
        next_cycle();
        chk_reset_values();
        reset = 1'b0;

        // Table-driven vectors, one per clock cycle.
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].m0_rd, vt[i].m0_wr, vt[i].m0_a, vt[i].m0_be, vt[i].m0_wd,
                  vt[i].m1_rd, vt[i].m1_wr, vt[i].m1_a, vt[i].m1_be, vt[i].m1_wd);
            @(negedge clk);
            chk($sformatf("v%0d_w0", i), {31'h0, m0_waitrequest}, {31'h0, vt[i].e_w0});
            chk($sformatf("v%0d_w1", i), {31'h0, m1_waitrequest}, {31'h0, vt[i].e_w1});
            chk($sformatf("v%0d_cs", i), {31'h0, mem_chipselect}, {31'h0, vt[i].e_cs});
            chk($sformatf("v%0d_mw", i), {31'h0, mem_write}, {31'h0, vt[i].e_mw});
            chk($sformatf("v%0d_clken", i), {31'h0, mem_clken}, 32'h1);
            if (vt[i].e_cs) chk($sformatf("v%0d_addr", i), {18'h0, mem_address}, {18'h0, vt[i].e_addr});
            if (vt[i].e_mw) begin
                chk($sformatf("v%0d_be", i), {28'h0, mem_byteenable}, {28'h0, vt[i].e_be});
                chk($sformatf("v%0d_wd", i), mem_writedata, vt[i].e_wd);
            end
            chk($sformatf("v%0d_rv0", i), {31'h0, m0_readdatavalid}, {31'h0, vt[i].e_rv0});
            chk($sformatf("v%0d_rd0", i), m0_readdata, vt[i].e_rd0);
            chk($sformatf("v%0d_rv1", i), {31'h0, m1_readdatavalid}, {31'h0, vt[i].e_rv1});
            chk($sformatf("v%0d_rd1", i), m1_readdata, vt[i].e_rd1);
            chk($sformatf("v%0d_err", i), {31'h0, oor_err}, {31'h0, vt[i].e_err});
            chk($sformatf("v%0d_cnt", i), {24'h0, oor_count}, {24'h0, vt[i].e_cnt});
            next_cycle();
        end

        // 300 more out-of-range writes: counter saturates at 255, RAM never selected.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 14'h2EE0, 4'hF, 32'h11111111, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (i == 0 || i == 299) begin
                chk($sformatf("sat%0d_cs", i), {31'h0, mem_chipselect}, 32'h0);
                chk($sformatf("sat%0d_w0", i), {31'h0, m0_waitrequest}, 32'h0);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("sat_cnt", {24'h0, oor_count}, 32'd255);
        chk("sat_err", {31'h0, oor_err}, 32'h1);
        chk("sat_ram_intact", ram[0], 32'hA5A50000);
        next_cycle();

        // Back-to-back: 8 consecutive m0 reads, then one idle cycle.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 14'h0030 + 14'(i), 4'hF, 32'h0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
            else       idle();
            @(negedge clk);
            if (i < 8) chk($sformatf("b2b%0d_w0", i), {31'h0, m0_waitrequest}, 32'h0);
            if (i > 0) begin
                chk($sformatf("b2b%0d_rv0", i), {31'h0, m0_readdatavalid}, 32'h1);
                chk($sformatf("b2b%0d_rd0", i), m0_readdata, 32'hA5A50030 + 32'(i - 1));
            end
            next_cycle();
        end

        // Reset mid-read: leave rr_ptr at 1, get an m1 read accepted, then pulse reset.
        drive(1'b1, 1'b0, 14'h0050, 4'hF, 32'h0, 1'b1, 1'b0, 14'h0040, 4'hF, 32'h0);
        @(negedge clk);
        chk("mr_pre_w0", {31'h0, m0_waitrequest}, 32'h0);
        chk("mr_pre_w1", {31'h0, m1_waitrequest}, 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b1, 1'b0, 14'h0040, 4'hF, 32'h0);
        @(negedge clk);
        chk("mr_acc_w1", {31'h0, m1_waitrequest}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 1'b0, 14'h0050, 4'hF, 32'h0, 1'b1, 1'b0, 14'h0040, 4'hF, 32'h0);
        #1;
        chk_reset_values();
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("mr_no_rv1", {31'h0, m1_readdatavalid}, 32'h0);
        chk("mr_no_rv0", {31'h0, m0_readdatavalid}, 32'h0);
        chk("mr_clken", {31'h0, mem_clken}, 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 14'h0050, 4'hF, 32'h0, 1'b1, 1'b0, 14'h0040, 4'hF, 32'h0);
        @(negedge clk);
        chk("mr_rr_w0", {31'h0, m0_waitrequest}, 32'h0);
        chk("mr_rr_w1", {31'h0, m1_waitrequest}, 32'h1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mr_post_rv0", {31'h0, m0_readdatavalid}, 32'h1);
        chk("mr_post_rd0", m0_readdata, 32'hA5A50050);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
